decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable. It is the successor to the team's fixed 3-to-8 combinational decoder. It adds sequential modes on top of direct decode:
- auto-scan up/down with programmable dwell
- timed single-output pulse

It drives row/column selects, LED multiplexing and chip-select strobes in the assignment designs.

Parameters:
N, 3, select width; output width is 2^N
DW, 8, width of dwell count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  output enable; 0 forces out to all zeros
mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 PULSE
in  input  N  select value / scan start index / pulse target
load  input  1  one-cycle strobe: capture in (scan start or pulse trigger)
dwell  input  DW  extra cycles each output is held (0 = one cycle)
out  output  2^N  registered one-hot (or all-zero) decode
idx  output  N  current active index register
busy  output  1  high while a PULSE is active
wrap  output  1  one-cycle pulse when a scan wraps

Behaviour:
- Reset (rst_n low, asynchronous): out=0, idx=0, dwell counter cnt=0, busy=0, wrap=0, state=IDLE.
- All outputs are registered. Decisions are taken on clock edge k and are visible after edge k.
- en=0:
  - out<=0, wrap<=0.
  - idx, cnt, state and busy are frozen (no advance, PULSE timer paused).
  - load is ignored.
  - When en returns to 1, operation resumes from the frozen state.
- DIRECT (mode 00): out<=1<<in, idx<=in every cycle. Latency is 1 clock. cnt is held at 0, and load and dwell are ignored.
- SCAN_UP / SCAN_DOWN:
  - out<=1<<idx_next, where idx_next is the idx value written on the same edge.
  - load=1: idx<=in, cnt<=0. Load has priority over advance.
  - Otherwise, if cnt>=dwell: cnt<=0 and idx<=idx±1 modulo 2^N. Otherwise cnt<=cnt+1.
  - Using >= means that lowering dwell mid-hold advances on the next edge.
  - wrap<=1 for one cycle when idx steps 2^N-1->0 (up) or 0->2^N-1 (down). No wrap is generated on a load.
  - Each index is active for exactly dwell+1 cycles.
- PULSE (mode 11). States are IDLE and ACTIVE.
  - IDLE: out<=0, busy=0. On load: idx<=in, cnt<=0, out<=1<<in, busy<=1, go to ACTIVE.
  - ACTIVE: if cnt>=dwell, out<=0, busy<=0, return to IDLE. Otherwise cnt<=cnt+1.
  - load while ACTIVE restarts the pulse on the new in, with cnt<=0.
  - The pulse width is exactly dwell+1 cycles.
- Mode change takes effect on the next edge. cnt<=0, state<=IDLE, busy<=0, wrap<=0, and idx is retained.
- Asserting rst_n low mid-scan or mid-pulse clears everything immediately. It does not wait for a clock.
- Width rules: idx arithmetic is N-bit unsigned with natural wrap. cnt is DW-bit and never exceeds dwell. out never has more than one bit set.

Decomposition:
- Shared package decoder_pkg:
  - mode encodings MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_PULSE
  - PULSE state encodings ST_IDLE, ST_ACTIVE
- One sub-module, dwell_timer:
  - contains the DW-bit cnt with clear/enable inputs
  - produces a terminal flag (cnt>=dwell)
  - is reused by the scan and pulse paths
- The one-hot decode is a function in the package: onehot(sel) returning 2^N bits.

Test Plan:
- Direct sweep: N=3, mode=00, drive {en,in}=0..15, one value per 10 time units -> one clock after each drive, out=0 for en=0, out=8'b1<<in for en=1 (in=5 -> 8'b00100000).
- Scan up: N=3, dwell=2, load in=6, then load=0 -> idx sequence 6,6,6,7,7,7,0,0,0,1. wrap is high for exactly one cycle, on the edge where idx becomes 0.
- Scan down with dwell=0: load in=1 -> idx 1,0,7,6 on consecutive cycles. wrap is high on the 0->7 step. out tracks 1<<idx.
- Pulse: mode=11, dwell=3, load in=4 -> out=8'b00010000 and busy=1 for exactly 4 cycles, then out=0 and busy=0. A second load in=2 at cycle 2 restarts the pulse, so out=8'b00000100 for 4 cycles from that point.
- Enable freeze: during scan at idx=3 with cnt=1, drop en for 5 cycles -> out=0 and idx=3 throughout. Re-enable -> idx=3 holds for the remaining dwell-cnt cycles, then advances to 4.
- Async reset mid-pulse: pull rst_n low between clock edges -> out, idx, busy and wrap go to 0 immediately, and stay 0 until load after rst_n is released.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block: mode and pulse-state
// encodings plus the one-hot decode helper.
package decoder_pkg;

  // Upper bound on the select width supported by onehot().
  localparam int unsigned MAX_N  = 8;
  localparam int unsigned MAX_OW = 1 << MAX_N;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_PULSE     = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_e;

  // One-hot decode of sel; callers truncate to their own 2^N width.
  function automatic logic [MAX_OW-1:0] onehot(input logic [MAX_N-1:0] sel);
    logic [MAX_OW-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter shared by the scan and pulse paths.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr_i      : clear count to zero (wins over inc_i)
//   inc_i      : increment count
//   dwell_i    : hold length in extra cycles
//   term_c     : combinational terminal flag, count >= dwell_i
module dwell_timer #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [DW-1:0] dwell_i,
  output logic          term_c
);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // Next count: clear has priority, otherwise optional increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= so that lowering dwell mid-hold terminates on the next edge.
  assign term_c = (cnt_q >= dwell_i);

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable, auto-scan up/down with
// programmable dwell, and a timed single-output pulse.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : output enable; low blanks out and freezes all other state
//   mode       : 00 direct, 01 scan up, 10 scan down, 11 pulse
//   in         : select value / scan start index / pulse target
//   load       : one-cycle strobe capturing in (scan start or pulse trigger)
//   dwell      : extra cycles each output is held
//   out        : registered one-hot (or all-zero) decode
//   idx        : current active index
//   busy       : high while a pulse is active
//   wrap       : one-cycle pulse when a scan wraps around
module decoder_scan #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      in,
  input  logic              load,
  input  logic [DW-1:0]     dwell,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              wrap
);

  import decoder_pkg::*;

  localparam int unsigned OW = 1 << N;
  localparam logic [N-1:0] IDX_MAX = N'(OW - 1);

  mode_e          mode_q,  mode_d;
  pulse_state_e   state_q, state_d;
  logic [OW-1:0]  out_q,   out_d;
  logic [N-1:0]   idx_q,   idx_d;
  logic           busy_q,  busy_d;
  logic           wrap_q,  wrap_d;

  logic           cnt_clr_c;
  logic           cnt_inc_c;
  logic           term_c;
  mode_e          mode_in_c;

  assign mode_in_c = mode_e'(mode);

  // Decode an N-bit index to this instance's output width.
  function automatic logic [OW-1:0] decode(input logic [N-1:0] s);
    return OW'(onehot(MAX_N'(s)));
  endfunction

  dwell_timer #(
    .DW (DW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr_c),
    .inc_i   (cnt_inc_c),
    .dwell_i (dwell),
    .term_c  (term_c)
  );

  // Next-state and output decisions for all modes.
  always_comb begin
    mode_d    = mode_q;
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    wrap_d    = 1'b0;
    out_d     = '0;
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;

    if (en) begin
      if (mode_in_c != mode_q) begin
        // Mode switch edge: drop any scan/pulse progress, keep idx.
        mode_d    = mode_in_c;
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        cnt_clr_c = 1'b1;
      end else begin
        unique case (mode_q)
          MODE_DIRECT: begin
            idx_d     = in;
            cnt_clr_c = 1'b1;
            out_d     = decode(in);
          end

          MODE_SCAN_UP, MODE_SCAN_DOWN: begin
            if (load) begin
              idx_d     = in;
              cnt_clr_c = 1'b1;
            end else if (term_c) begin
              cnt_clr_c = 1'b1;
              if (mode_q == MODE_SCAN_UP) begin
                idx_d  = idx_q + N'(1);
                wrap_d = (idx_q == IDX_MAX);
              end else begin
                idx_d  = idx_q - N'(1);
                wrap_d = (idx_q == '0);
              end
            end else begin
              cnt_inc_c = 1'b1;
            end
            out_d = decode(idx_d);
          end

          MODE_PULSE: begin
            if (load) begin
              // Trigger, or retrigger while active, on the new target.
              idx_d     = in;
              cnt_clr_c = 1'b1;
              busy_d    = 1'b1;
              state_d   = ST_ACTIVE;
              out_d     = decode(in);
            end else if (state_q == ST_ACTIVE) begin
              if (term_c) begin
                cnt_clr_c = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
              end else begin
                cnt_inc_c = 1'b1;
                out_d     = decode(idx_q);
              end
            end
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_DIRECT;
      state_q <= ST_IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: direct-decode table, directed
// scan/pulse/enable/reset sequences and a randomized run against a model.
module tb_decoder_scan;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 1 << N;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [N-1:0]  in;
  logic          load;
  logic [DW-1:0] dwell;
  logic [OW-1:0] out;
  logic [N-1:0]  idx;
  logic          busy;
  logic          wrap;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers).
  int            m_mode;
  int            m_idx;
  int            m_cnt;
  bit            m_act;
  bit            m_busy;
  bit            m_wrap;
  logic [OW-1:0] m_out;

  typedef struct {
    logic          en;
    logic [N-1:0]  in;
    logic [OW-1:0] exp_out;
  } vec_t;

  vec_t tbl[16];
  int   exp_up[10];

  decoder_scan #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .in    (in),
    .load  (load),
    .dwell (dwell),
    .out   (out),
    .idx   (idx),
    .busy  (busy),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] oh(input int i);
    return OW'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_cnt = 0;
    m_act = 0; m_busy = 0; m_wrap = 0; m_out = '0;
  endtask

  // Apply one clock edge's worth of behaviour using the present inputs.
  task automatic model_edge();
    if (!en) begin
      m_out  = '0;
      m_wrap = 0;
      return;
    end
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_cnt = 0; m_act = 0; m_busy = 0; m_wrap = 0; m_out = '0;
      return;
    end
    m_wrap = 0;
    case (m_mode)
      0: begin
        m_idx = int'(in);
        m_cnt = 0;
        m_out = oh(m_idx);
      end
      1, 2: begin
        if (load) begin
          m_idx = int'(in);
          m_cnt = 0;
        end else if (m_cnt >= int'(dwell)) begin
          if (m_mode == 1) begin
            m_wrap = (m_idx == OW - 1);
            m_idx  = (m_idx + 1) % OW;
          end else begin
            m_wrap = (m_idx == 0);
            m_idx  = (m_idx + OW - 1) % OW;
          end
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
        m_out = oh(m_idx);
      end
      default: begin
        if (load) begin
          m_idx = int'(in);
          m_cnt = 0;
          m_act = 1;
        end else if (m_act) begin
          if (m_cnt >= int'(dwell)) begin
            m_act = 0;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        m_busy = m_act;
        m_out  = m_act ? oh(m_idx) : '0;
      end
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("rnd_out",  32'(out),  32'(m_out));
    chk("rnd_idx",  32'(idx),  32'(m_idx));
    chk("rnd_busy", 32'(busy), 32'(m_busy));
    chk("rnd_wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; in = '0; load = 1'b0; dwell = '0;
    model_reset();
    #12;
    chk("reset_out",  32'(out),  32'h0);
    chk("reset_idx",  32'(idx),  32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;

    // Direct sweep over {en,in}.
    for (int i = 0; i < 16; i++) begin
      tbl[i].en      = (i >= 8);
      tbl[i].in      = N'(i % 8);
      tbl[i].exp_out = (i >= 8) ? oh(i % 8) : '0;
    end
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; in = tbl[i].in;
      tick();
      chk("direct_out", 32'(out), 32'(tbl[i].exp_out));
    end
    in = 3'd5; en = 1'b1;
    tick();
    chk("direct_in5", 32'(out), 32'h20);

    // Scan up, dwell=2, start at 6.
    exp_up = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
    mode = 2'b01; dwell = 8'd2;
    tick();
    in = 3'd6; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      chk("scanup_idx",  32'(idx),  32'(exp_up[k]));
      chk("scanup_out",  32'(out),  32'(oh(exp_up[k])));
      chk("scanup_wrap", 32'(wrap), (k == 6) ? 32'h1 : 32'h0);
    end

    // Scan down, dwell=0, start at 1.
    mode = 2'b10; dwell = 8'd0;
    tick();
    in = 3'd1; load = 1'b1;
    tick();
    load = 1'b0;
    chk("scandn_idx0", 32'(idx), 32'd1);
    tick();
    chk("scandn_idx1", 32'(idx), 32'd0);
    chk("scandn_wrap1", 32'(wrap), 32'h0);
    tick();
    chk("scandn_idx2", 32'(idx), 32'd7);
    chk("scandn_wrap2", 32'(wrap), 32'h1);
    chk("scandn_out2", 32'(out), 32'h80);
    tick();
    chk("scandn_idx3", 32'(idx), 32'd6);
    chk("scandn_wrap3", 32'(wrap), 32'h0);

    // Enable freeze at idx=3, cnt=1.
    mode = 2'b01; dwell = 8'd2;
    tick();
    in = 3'd3; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("freeze_out", 32'(out), 32'h0);
      chk("freeze_idx", 32'(idx), 32'd3);
    end
    en = 1'b1;
    tick();
    chk("resume_idx", 32'(idx), 32'd3);
    chk("resume_out", 32'(out), 32'h08);
    tick();
    chk("advance_idx", 32'(idx), 32'd4);

    // Pulse, dwell=3, target 4.
    mode = 2'b11;
    tick();
    chk("pulse_modechg_out", 32'(out), 32'h0);
    dwell = 8'd3; in = 3'd4; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("pulse_out",  32'(out),  32'h10);
      chk("pulse_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("pulse_end_out",  32'(out),  32'h0);
    chk("pulse_end_busy", 32'(busy), 32'h0);

    // Retrigger at cycle 2 on target 2.
    in = 3'd4; load = 1'b1;
    tick();
    load = 1'b0;
    chk("retrig_p0", 32'(out), 32'h10);
    tick();
    chk("retrig_p1", 32'(out), 32'h10);
    in = 3'd2; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("retrig_out",  32'(out),  32'h04);
      chk("retrig_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("retrig_end_out", 32'(out), 32'h0);

    // Asynchronous reset mid-pulse.
    in = 3'd5; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("prerst_busy", 32'(busy), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out",  32'(out),  32'h0);
    chk("arst_idx",  32'(idx),  32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("postrst_out",  32'(out),  32'h0);
      chk("postrst_busy", 32'(busy), 32'h0);
    end
    in = 3'd1; load = 1'b1;
    tick();
    load = 1'b0;
    chk("postrst_load_out", 32'(out), 32'h02);

    // Randomized run against the model.
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) dwell = DW'($urandom_range(0, 3));
      in   = N'($urandom);
      load = ($urandom_range(0, 5) == 0);
      tick();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
